spi_master_ctrl: RTL
====================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 2: i_clk cycles per SCK half-period; legal range 1..255.
REQ-002 Parameter GAP_CYC, default 4: i_clk cycles between the address byte and the data byte; legal range 1..255.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_start  input  1  transaction request; sampled only in IDLE.
REQ-006 i_addr  input  8  address byte; latched on the accepted i_start.
REQ-007 i_abort  input  1  cancels an in-progress transaction.
REQ-008 i_miso  input  1  serial data from slave.
REQ-009 o_sck  output  1  SPI clock, mode 0, idle low.
REQ-010 o_cs_n  output  1  slave select, active-low.
REQ-011 o_mosi  output  1  serial data to slave, MSB first.
REQ-012 o_busy  output  1  high in every state except IDLE.
REQ-013 o_done  output  1  one-cycle pulse on successful completion.
REQ-014 o_rdata  output  8  byte read from slave; holds its value until the next o_done.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, ADDR, GAP, DATA, HOLD, DONE.
REQ-016 IDLE: cs_n=1, sck=0, mosi=0; i_start=1 latches i_addr, loads shift register, moves to SETUP next cycle; i_start=0 stays IDLE.
REQ-017 Divider counter SHALL count 0..CLK_DIV-1; a "tick" is the cycle where it equals CLK_DIV-1; counter clears on every state entry.
REQ-018 SETUP: cs_n=0, sck=0, mosi=addr[7]; lasts exactly CLK_DIV cycles, then ADDR.
REQ-019 ADDR: each tick toggles sck; 16 ticks (8 rising, 8 falling edges); mosi shifts to next address bit on each falling edge; after the 16th tick (sck back to 0) go to GAP.
REQ-020 GAP: cs_n=0, sck=0, mosi=0; lasts exactly GAP_CYC cycles, then DATA.
REQ-021 DATA: 16 ticks as in ADDR, mosi=0; i_miso sampled into receive shift register, MSB first, in the cycle sck goes 0->1.
REQ-022 HOLD: cs_n=0, sck=0; lasts CLK_DIV cycles, then DONE.
REQ-023 DONE: cs_n=1, o_done=1 for exactly one cycle, o_rdata loaded from receive shift register; next state IDLE unconditionally; i_start in DONE ignored.
REQ-024 Latency: accepted i_start at cycle T0 -> o_done at T0+1+34*CLK_DIV+GAP_CYC (CLK_DIV=2, GAP_CYC=4: T0+73).
REQ-025 Back-to-back: earliest next accepted i_start is the cycle after DONE; cs_n high for at least 2 cycles between transactions.
REQ-026 Bit counter SHALL be 4 bits and clear on entry to ADDR and DATA; no wrap beyond 16 ticks.
REQ-027 i_abort=1 in any non-IDLE state: next cycle IDLE, cs_n=1, sck=0, mosi=0, no o_done, o_rdata unchanged; i_abort in IDLE ignored.
REQ-028 Priority: i_rst > i_abort > normal sequencing; simultaneous i_start and i_abort in IDLE starts a transaction.

Reset
REQ-029 i_rst=1 at a clock edge SHALL force IDLE; o_cs_n=1, o_sck=0, o_mosi=0, o_busy=0, o_done=0, o_rdata=8'h00; all counters and shift registers cleared.
REQ-030 Reset mid-transaction SHALL behave as REQ-029 with no o_done pulse.

Verification
REQ-031 CLK_DIV=2, GAP_CYC=4, i_addr=8'hA5, slave returns 8'h3C -> mosi bits 1,0,1,0,0,1,0,1 stable on each sck rise; o_rdata=8'h3C; o_done exactly at T0+73.
REQ-032 CLK_DIV=1, i_addr=8'h80, i_miso held 1 -> sck toggles every cycle in ADDR/DATA; o_rdata=8'hFF.
REQ-033 i_abort asserted on 3rd sck rise of DATA -> cs_n=1 next cycle, no o_done, o_rdata keeps previous value.
REQ-034 i_start held high continuously for two transactions -> second SETUP begins the cycle after IDLE is re-entered, cs_n high for 2 cycles in between.
REQ-035 i_rst asserted during GAP -> all outputs at reset values next cycle; i_start the cycle after reset release completes a normal transaction.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one address byte out, a programmable gap, then one data byte in.
// Single clock, synchronous active-high reset; i_abort returns to IDLE without o_done.
module spi_master_ctrl #(
   parameter int CLK_DIV = 2,
   parameter int GAP_CYC = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [7:0] i_addr,
   input  logic       i_abort,
   input  logic       i_miso,
   output logic       o_sck,
   output logic       o_cs_n,
   output logic       o_mosi,
   output logic       o_busy,
   output logic       o_done,
   output logic [7:0] o_rdata
);

   typedef enum logic [2:0] {IDLE, SETUP, ADDR, GAP, DATA, HOLD, DONE} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] bit_q, bit_d;
   logic       sck_q, sck_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] rdata_q, rdata_d;
   logic       tick;

   assign tick = (cnt_q == DIV_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sck_q   <= 1'b0;
         shift_q <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sck_q   <= sck_d;
         shift_q <= shift_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 8'd1;
      bit_d   = bit_q;
      sck_d   = sck_q;
      shift_d = shift_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            sck_d = 1'b0;
            if (i_start) begin
               shift_d = i_addr;
               rx_d    = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (tick) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (tick) begin
               cnt_d = '0;
               sck_d = ~sck_q;
               bit_d = bit_q + 4'd1;
               // Advance to the next address bit only on the falling edge.
               if (sck_q) shift_d = {shift_q[6:0], 1'b0};
               if (bit_q == 4'd15) state_d = GAP;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               cnt_d = '0;
               sck_d = ~sck_q;
               bit_d = bit_q + 4'd1;
               if (!sck_q) rx_d = {rx_q[6:0], i_miso};
               if (bit_q == 4'd15) state_d = HOLD;
            end
         end
         HOLD: begin
            if (tick) begin
               cnt_d   = '0;
               rdata_d = rx_q;
               state_d = DONE;
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
      // Abort wins over all sequencing and discards any pending read result.
      if (i_abort && (state_q != IDLE)) begin
         state_d = IDLE;
         cnt_d   = '0;
         bit_d   = '0;
         sck_d   = 1'b0;
         rdata_d = rdata_q;
      end
   end

   assign o_sck   = sck_q;
   assign o_cs_n  = (state_q == IDLE) || (state_q == DONE);
   assign o_mosi  = ((state_q == SETUP) || (state_q == ADDR)) && shift_q[7];
   assign o_busy  = (state_q != IDLE);
   assign o_done  = (state_q == DONE);
   assign o_rdata = rdata_q;

endmodule
